// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bp_pkg
// Description : Shared definitions for the IF-stage branch predictor.
//               Counter encodings, PC-to-index/tag helpers, and the
//               reference entry layout for the default 16-entry, 32-bit
//               configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // 2-bit direction counter encodings. The MSB is the taken prediction.
    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_WEAK_T  = 2'b10;

    // Geometry of the default configuration, used by bp_entry_t.
    localparam int BP_DEF_PC_W  = 32;
    localparam int BP_DEF_IDX_W = 4;
    localparam int BP_DEF_TAG_W = BP_DEF_PC_W - BP_DEF_IDX_W - 2;

    // One table entry for the default geometry. The parametrised top uses a
    // local struct with the same field order.
    typedef struct packed {
        logic                    valid;
        logic [BP_DEF_TAG_W-1:0] tag;
        logic [BP_DEF_PC_W-1:0]  target;
        logic [1:0]              cnt;
    } bp_entry_t;

    // Index = pc[idx_w+1:2]. Operates on a 64-bit widened PC; callers
    // truncate the result to their index width.
    function automatic logic [63:0] idx_of(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag = pc[PC_W-1:idx_w+2]. Callers truncate to their tag width.
    function automatic logic [63:0] tag_of(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up/down counter that saturates at 0 and 2^W-1, with a
//               synchronous load that takes priority over counting.
//               Simultaneous inc and dec hold the value.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_inc, i_dec    - count up / down by one
//               i_load, i_load_val - load a value
//               o_cnt           - current count (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && !i_dec && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with per-entry saturating
//               direction counters. Combinational lookup for the IF PC,
//               training from ID-stage branch resolution.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               lookup_pc                      - IF fetch PC
//               pred_hit/pred_taken/pred_target - prediction for lookup_pc
//               upd_valid/upd_pc/upd_taken/upd_target/upd_mispredict
//                                              - resolved branch from ID
//               flush_all                      - invalidate all entries
//               stat_lookups/stat_mispredicts  - saturating perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict,
    input  logic              flush_all,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Weak encodings for any counter width: 0111.. and 1000..
    localparam logic [CNT_W-1:0] c_WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] c_WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [PC_W-1:0]    r_target [ENTRIES];
    logic [CNT_W-1:0]   w_cnt    [ENTRIES];

    logic [IDX_W-1:0] w_look_idx, w_upd_idx;
    logic [TAG_W-1:0] w_look_tag, w_upd_tag;
    entry_t           w_look_ent;
    logic             w_hit;
    logic             w_upd_en, w_upd_hit, w_alloc, w_train;

    assign w_look_idx = IDX_W'(idx_of(64'(lookup_pc), IDX_W));
    assign w_look_tag = TAG_W'(tag_of(64'(lookup_pc), IDX_W));
    assign w_upd_idx  = IDX_W'(idx_of(64'(upd_pc), IDX_W));
    assign w_upd_tag  = TAG_W'(tag_of(64'(upd_pc), IDX_W));

    // ---------------- Lookup (reads registered state only, no bypass) ------
    assign w_look_ent = '{valid:  r_valid[w_look_idx],
                          tag:    r_tag[w_look_idx],
                          target: r_target[w_look_idx],
                          cnt:    w_cnt[w_look_idx]};

    assign w_hit       = w_look_ent.valid && (w_look_ent.tag == w_look_tag);
    assign pred_hit    = w_hit;
    assign pred_taken  = w_hit && w_look_ent.cnt[CNT_W-1];
    assign pred_target = w_hit ? w_look_ent.target : '0;

    // ---------------- Update ----------------------------------------------
    // Flush suppresses the update entirely.
    assign w_upd_en  = upd_valid && !flush_all;
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_alloc   = w_upd_en && !w_upd_hit && upd_taken;
    assign w_train   = w_upd_en && w_upd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (flush_all) begin
            r_valid <= '0;
        end else if (w_upd_en && upd_taken) begin
            // Taken outcome: refresh target on a hit, allocate on a miss.
            r_target[w_upd_idx] <= upd_target;
            if (!w_upd_hit) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_tag[w_upd_idx]   <= w_upd_tag;
            end
        end
    end

    // ---------------- Per-entry direction counters -------------------------
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic w_sel;
        assign w_sel = (w_upd_idx == IDX_W'(gi));

        sat_counter #(
            .W       (CNT_W),
            .RST_VAL (c_WEAK_NT)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_inc      (w_train && w_sel && upd_taken),
            .i_dec      (w_train && w_sel && !upd_taken),
            .i_load     (w_alloc && w_sel),
            .i_load_val (c_WEAK_T),
            .o_cnt      (w_cnt[gi])
        );
    end

    // ---------------- Performance counters ---------------------------------
    // Mispredicts are counted even in a flush cycle.
    sat_counter #(
        .W       (STAT_W),
        .RST_VAL ('0)
    ) u_stat_lookups (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_hit),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_cnt      (stat_lookups)
    );

    sat_counter #(
        .W       (STAT_W),
        .RST_VAL ('0)
    ) u_stat_mispredicts (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (upd_valid && upd_mispredict),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_cnt      (stat_mispredicts)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor
//               (16 entries, 32-bit PC, 2-bit counters, 4-bit statistics).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int          PC_W   = 32;
    localparam int          STAT_W = 4;
    localparam logic [31:0] MISS   = 32'h0000_0440;  // index 0, tag differs from 0x40

    logic              clk;
    logic              rst_n;
    logic [PC_W-1:0]   lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              upd_mispredict;
    logic              flush_all;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_mispredicts;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor #(
        .ENTRIES (16),
        .PC_W    (PC_W),
        .CNT_W   (2),
        .STAT_W  (STAT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .flush_all        (flush_all),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One resolved branch; the lookup PC is parked on a miss address so the
    // lookup statistic does not move.
    task automatic upd(input logic [31:0] pc, input logic taken,
                       input logic [31:0] target, input logic mispred);
        lookup_pc      = MISS;
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = target;
        upd_mispredict = mispred;
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        lookup_pc      = 32'h40;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_mispredict = 1'b0;
        flush_all      = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_hit",    64'(pred_hit),         64'd0);
        check("rst_taken",  64'(pred_taken),       64'd0);
        check("rst_target", 64'(pred_target),      64'd0);
        check("rst_stat_l", 64'(stat_lookups),     64'd0);
        check("rst_stat_m", 64'(stat_mispredicts), 64'd0);

        // Update and lookup of the same PC in one cycle: no bypass
        lookup_pc  = 32'h40;
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_target = 32'h80;
        #1;
        check("same_cycle_hit", 64'(pred_hit), 64'd0);
        step();
        upd_valid = 1'b0;
        check("alloc_hit",    64'(pred_hit),    64'd1);
        check("alloc_taken",  64'(pred_taken),  64'd1);
        check("alloc_target", 64'(pred_target), 64'h80);
        look(MISS);
        check("alias_hit",    64'(pred_hit),    64'd0);
        check("alias_target", 64'(pred_target), 64'd0);

        // Training: 10 -> 01 -> 00 -> 00
        upd(32'h40, 1'b0, 32'h999, 1'b0);
        upd(32'h40, 1'b0, 32'h999, 1'b0);
        upd(32'h40, 1'b0, 32'h999, 1'b0);
        look(32'h40);
        check("nt3_hit",    64'(pred_hit),    64'd1);
        check("nt3_taken",  64'(pred_taken),  64'd0);
        check("nt3_target", 64'(pred_target), 64'h80);
        // 00 -> 01 -> 10, target refreshed by the taken updates
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        look(32'h40);
        check("t1_taken", 64'(pred_taken), 64'd0);
        upd(32'h40, 1'b1, 32'hC0, 1'b0);
        look(32'h40);
        check("t2_taken",  64'(pred_taken),  64'd1);
        check("t2_target", 64'(pred_target), 64'hC0);

        // Not-taken on a cold entry does not allocate
        upd(32'h44, 1'b0, 32'h200, 1'b0);
        look(32'h44);
        check("noalloc_hit", 64'(pred_hit), 64'd0);

        // Upper saturation: 10 -> 11 -> 11, then one not-taken -> 10
        upd(32'h40, 1'b1, 32'hC0, 1'b0);
        upd(32'h40, 1'b1, 32'hC0, 1'b0);
        upd(32'h40, 1'b0, 32'h0,  1'b0);
        look(32'h40);
        check("sat_hi_taken", 64'(pred_taken), 64'd1);

        // Lookup statistic: three edges with a hitting lookup PC
        check("stat_l_0", 64'(stat_lookups), 64'd0);
        step();
        step();
        step();
        check("stat_l_3", 64'(stat_lookups), 64'd3);
        lookup_pc = MISS;

        // Flush wins over a same-cycle update; mispredict still counted
        upd_valid      = 1'b1;
        upd_pc         = 32'h48;
        upd_taken      = 1'b1;
        upd_target     = 32'h100;
        upd_mispredict = 1'b1;
        flush_all      = 1'b1;
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        flush_all      = 1'b0;
        look(32'h40);
        check("flush_hit_40", 64'(pred_hit), 64'd0);
        look(32'h48);
        check("flush_hit_48", 64'(pred_hit), 64'd0);
        check("flush_stat_m", 64'(stat_mispredicts), 64'd1);
        check("flush_stat_l", 64'(stat_lookups),     64'd3);

        // Re-allocation after flush
        upd(32'h40, 1'b1, 32'h300, 1'b0);
        look(32'h40);
        check("realloc_taken",  64'(pred_taken),  64'd1);
        check("realloc_target", 64'(pred_target), 64'h300);

        // Mispredict statistic saturates at 15
        for (int i = 0; i < 5; i++) upd(32'h4C, 1'b0, 32'h0, 1'b1);
        check("stat_m_6", 64'(stat_mispredicts), 64'd6);
        for (int i = 0; i < 15; i++) upd(32'h4C, 1'b0, 32'h0, 1'b1);
        check("stat_m_sat", 64'(stat_mispredicts), 64'd15);

        // Asynchronous reset mid-cycle
        look(32'h40);
        check("pre_rst_hit", 64'(pred_hit), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_hit",    64'(pred_hit),         64'd0);
        check("arst_taken",  64'(pred_taken),       64'd0);
        check("arst_target", 64'(pred_target),      64'd0);
        check("arst_stat_l", 64'(stat_lookups),     64'd0);
        check("arst_stat_m", 64'(stat_mispredicts), 64'd0);

        // An update on an edge while reset is held is lost
        upd_valid  = 1'b1;
        upd_pc     = 32'h50;
        upd_taken  = 1'b1;
        upd_target = 32'h500;
        step();
        upd_valid = 1'b0;
        rst_n     = 1'b1;
        look(32'h50);
        check("rst_upd_lost", 64'(pred_hit), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised branch target buffer with per-entry 2-bit saturating direction counters, used in the IF stage of the five-stage pipeline.
- Predicts taken/target for the current fetch PC in the same cycle.
- Is trained from the ID-stage branch resolution (Suber/BranchUnit outcome).
- Replaces the fixed "predict not-taken, resolve in ID" scheme and removes the branch bubble on correctly predicted taken branches.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of two, 2..1024.
PC_W, 32, program counter width.
CNT_W, 2, direction counter width; MSB set means predict taken.
STAT_W, 16, width of the performance counters.
Derived: IDX_W = log2(ENTRIES); TAG_W = PC_W - IDX_W - 2.

Ports:
clk  input  1  pipeline clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
lookup_pc  input  PC_W  fetch PC of the current IF instruction.
pred_hit  output  1  valid entry with matching tag.
pred_taken  output  1  pred_hit AND counter MSB.
pred_target  output  PC_W  stored target; 0 when pred_hit=0.
upd_valid  input  1  resolved conditional branch present in ID this cycle.
upd_pc  input  PC_W  PC of the resolved branch.
upd_taken  input  1  actual direction.
upd_target  input  PC_W  actual taken target (pcBranch).
upd_mispredict  input  1  prediction carried down the pipe disagreed with the outcome.
flush_all  input  1  invalidate every entry.
stat_lookups  output  STAT_W  count of cycles with pred_hit=1.
stat_mispredicts  output  STAT_W  count of upd_valid & upd_mispredict.

Behaviour:
- Reset (async, rst_n=0):
  - all valid bits 0; counters = 01 (weakly not-taken); tags/targets 0.
  - stat_lookups = stat_mispredicts = 0.
  - outputs therefore pred_hit=0, pred_taken=0, pred_target=0.
- Addressing: index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] is ignored.
- Lookup is purely combinational from registered state, with zero-cycle latency. There is no bypass: a same-cycle update to the same index is not visible until the next cycle.
- Update is applied on the rising edge when upd_valid=1:
  - Tag hit: counter increments if upd_taken, else decrements, saturating at 0 and 2^CNT_W-1. Target is overwritten only when upd_taken=1.
  - Tag miss or invalid, with upd_taken=1: allocate the entry. valid=1, tag written, target=upd_target, counter=10 (weakly taken).
  - Tag miss or invalid, with upd_taken=0: no allocation; table unchanged.
- Example counter sequence for CNT_W=2 on repeated taken: 01→10→11→11. On not-taken: 11→10→01→00→00.
- flush_all=1: all valid bits cleared on the next edge; counters and targets are untouched.
  - flush_all and upd_valid in the same cycle: flush wins and the update is dropped.
  - The mispredict statistic still counts in that cycle.
- Performance counters saturate at 2^STAT_W-1 and never wrap. They are cleared only by reset, not by flush.
- Reset mid-update: asynchronous reset dominates; the edge's update is lost.
- Stall interaction: none. The caller gates upd_valid; the block holds no pipeline state.
- Storage is flops (no RAM inference requirement). Writes and the counter update complete within one cycle.

Decomposition:
- Shared package bp_pkg holds:
  - constants CNT_WEAK_NT = 2'b01 and CNT_WEAK_T = 2'b10;
  - the functions idx_of(pc) and tag_of(pc);
  - a typedef for one entry {valid, tag, target, cnt}.
- One sub-module is natural: sat_counter (parametrised CNT_W, with inc/dec/load inputs). It is instantiated per entry and reused for the two stat counters with STAT_W.

Test Plan:
1. After reset, lookup_pc=0x0000_0040 → pred_hit=0, pred_taken=0, pred_target=0, stats 0.
2. upd pc=0x40, taken=1, target=0x80 → next cycle lookup 0x40: hit=1, taken=1, target=0x80. Lookup 0x440 (same index 0, different tag): hit=0.
3. Counter training at pc=0x40: three not-taken updates → counter 00, pred_taken=0, pred_hit=1. Then two taken updates → 10, pred_taken=1.
4. Simultaneous update (0x40, taken) and lookup 0x40 on a cold table → lookup returns hit=0 that cycle and hit=1 the next cycle.
5. flush_all with upd_valid=1, upd_mispredict=1 in the same cycle → all hits 0 next cycle; update dropped; stat_mispredicts=1.
6. With STAT_W=4, 20 mispredicting updates → stat_mispredicts stays at 15. Assert rst_n=0 mid-sequence → all outputs 0 immediately, without waiting for a clock edge.
